// File: rtl/jtcontra_colmix.sv
// Contra colour mixer: 007121 layer priority, palette RAM fetch and RGB out.
// Optional layer masking via gfx_en when JTCONTRA_LAYER_MASK_EN is defined.
module jtcontra_colmix (
    input  logic       rst,
    input  logic       clk24,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [7:0] pxl_a,
    input  logic [7:0] pxl_b,
    input  logic [1:0] gfx_en,
    input  logic       pal_cs,
    input  logic       cpu_rnw,
    input  logic       cpu_cen,
    input  logic [8:0] cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    output logic [4:0] red,
    output logic [4:0] green,
    output logic [4:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    typedef enum logic [1:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WAIT
    } state_t;

    state_t     st;
    logic [7:0] pal [0:511];
    logic [7:0] idx;
    logic [7:0] nidx;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] pen_a;
    logic [3:0] pen_b;
    logic       lhbl1;
    logic       lvbl1;
    logic       unused;

    always_ff @(posedge clk24) begin
        if (pal_cs & ~cpu_rnw & cpu_cen)
            pal[cpu_addr] <= cpu_dout;
    end

    assign pal_dout = pal[cpu_addr];

    // front layer wins unless its pen is transparent
    always_comb begin
        pen_a = pxl_a[3:0];
        pen_b = pxl_b[3:0];
`ifdef JTCONTRA_LAYER_MASK_EN
        if (!gfx_en[0]) pen_a = 4'h0;
        if (!gfx_en[1]) pen_b = 4'h0;
`endif
        nidx = (pen_b != 4'h0) ? {1'b1, pxl_b[6:4], pen_b}
                               : {1'b0, pxl_a[6:4], pen_a};
    end

`ifdef JTCONTRA_LAYER_MASK_EN
    assign unused = ^{pxl_a[7], pxl_b[7], hi[7]};
`else
    assign unused = ^{pxl_a[7], pxl_b[7], hi[7], gfx_en};
`endif

    always_ff @(posedge clk24) begin
        if (rst) begin
            st       <= IDLE;
            idx      <= 8'h00;
            lo       <= 8'h00;
            hi       <= 8'h00;
            lhbl1    <= 1'b0;
            lvbl1    <= 1'b0;
            red      <= 5'd0;
            green    <= 5'd0;
            blue     <= 5'd0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else begin
            if (pxl_cen) begin
                lhbl1    <= LHBL;
                lvbl1    <= LVBL;
                LHBL_dly <= lhbl1;
                LVBL_dly <= lvbl1;
                if (lhbl1 & lvbl1) begin
                    red   <= lo[4:0];
                    green <= {hi[1:0], lo[7:5]};
                    blue  <= hi[6:2];
                end else begin
                    red   <= 5'd0;
                    green <= 5'd0;
                    blue  <= 5'd0;
                end
            end
            // a pixel pulse mid-fetch keeps the fetch address stable
            unique case (st)
                IDLE, WAIT: begin
                    if (pxl_cen) begin
                        idx <= nidx;
                        st  <= RD_LO;
                    end
                end
                RD_LO: begin
                    lo <= pal[{idx, 1'b0}];
                    st <= RD_HI;
                end
                RD_HI: begin
                    hi <= pal[{idx, 1'b1}];
                    st <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtcontra_colmix.sv
// Bench for jtcontra_colmix: directed colour cases plus random pixels
// checked against a palette model kept in the bench.
module tb_jtcontra_colmix;

    logic       rst = 1'b1;
    logic       clk24 = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b1;
    logic       LVBL = 1'b1;
    logic [7:0] pxl_a = 8'h00;
    logic [7:0] pxl_b = 8'h00;
    logic [1:0] gfx_en = 2'b11;
    logic       pal_cs = 1'b0;
    logic       cpu_rnw = 1'b1;
    logic       cpu_cen = 1'b0;
    logic [8:0] cpu_addr = 9'h000;
    logic [7:0] cpu_dout = 8'h00;
    logic [7:0] pal_dout;
    logic [4:0] red;
    logic [4:0] green;
    logic [4:0] blue;
    logic       LHBL_dly;
    logic       LVBL_dly;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:511];
    logic [14:0] prev_rgb = 15'd0;
    logic [1:0]  prev_blk = 2'b00;

    jtcontra_colmix dut (
        .rst      (rst),
        .clk24    (clk24),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .pxl_a    (pxl_a),
        .pxl_b    (pxl_b),
        .gfx_en   (gfx_en),
        .pal_cs   (pal_cs),
        .cpu_rnw  (cpu_rnw),
        .cpu_cen  (cpu_cen),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .pal_dout (pal_dout),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk24 = ~clk24;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which palette entry a pixel should show
    function automatic logic [7:0] pal_entry(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [1:0] en);
        int pa;
        int pb;
        pa = a % 16;
        pb = b % 16;
`ifdef JTCONTRA_LAYER_MASK_EN
        if (en[0] == 1'b0) pa = 0;
        if (en[1] == 1'b0) pb = 0;
`else
        if (en == 2'b10) pa = pa;
`endif
        if (pb != 0) return 8'(128 + ((b / 16) % 8) * 16 + pb);
        return 8'(((a / 16) % 8) * 16 + pa);
    endfunction

    function automatic logic [14:0] colour(input logic [7:0] n);
        int lo;
        int hi;
        int r;
        int g;
        int b;
        lo = int'(mem[2 * n]);
        hi = int'(mem[2 * n + 1]);
        r  = lo % 32;
        g  = lo / 32 + (hi % 4) * 8;
        b  = (hi / 4) % 32;
        return {5'(r), 5'(g), 5'(b)};
    endfunction

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk24);
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_cen  = 1'b1;
        cpu_addr = a;
        cpu_dout = d;
        @(posedge clk24);
        #1;
        pal_cs  = 1'b0;
        cpu_rnw = 1'b1;
        cpu_cen = 1'b0;
        mem[a]  = d;
    endtask

    task automatic cpu_rd(input logic [8:0] a);
        @(negedge clk24);
        cpu_addr = a;
        #1;
        chk("readback", 32'(pal_dout), 32'(mem[a]));
    endtask

    // mode 0: plain pixel, 1: CPU write to low byte during RD_LO,
    // 2: reset pulse during RD_HI
    task automatic pixel(input logic [7:0] a, input logic [7:0] b,
                         input logic lh, input logic lv,
                         input logic [1:0] en, input int mode,
                         input logic [7:0] wd);
        logic [7:0]  e;
        logic [14:0] cur;
        e   = pal_entry(a, b, en);
        cur = (lh && lv) ? colour(e) : 15'd0;
        @(negedge clk24);
        pxl_a   = a;
        pxl_b   = b;
        LHBL    = lh;
        LVBL    = lv;
        gfx_en  = en;
        pxl_cen = 1'b1;
        @(posedge clk24);
        #1;
        pxl_cen = 1'b0;
        chk("rgb", 32'({red, green, blue}), 32'(prev_rgb));
        chk("blank_dly", 32'({LHBL_dly, LVBL_dly}), 32'(prev_blk));
        @(negedge clk24);
        if (mode == 1) begin
            pal_cs   = 1'b1;
            cpu_rnw  = 1'b0;
            cpu_cen  = 1'b1;
            cpu_addr = {e, 1'b0};
            cpu_dout = wd;
        end
        @(posedge clk24);
        #1;
        pal_cs  = 1'b0;
        cpu_rnw = 1'b1;
        cpu_cen = 1'b0;
        if (mode == 1) mem[{e, 1'b0}] = wd;
        if (mode == 2) begin
            @(negedge clk24);
            rst = 1'b1;
            @(posedge clk24);
            #1;
            chk("rst_rgb", 32'({red, green, blue}), 32'd0);
            chk("rst_dly", 32'({LHBL_dly, LVBL_dly}), 32'd0);
            @(negedge clk24);
            rst = 1'b0;
            @(posedge clk24);
            prev_rgb = 15'd0;
            prev_blk = 2'b00;
        end else begin
            @(posedge clk24);
            @(posedge clk24);
            #1;
            chk("hold_rgb", 32'({red, green, blue}), 32'(prev_rgb));
            prev_rgb = cur;
            prev_blk = {lh, lv};
        end
    endtask

    initial begin
        repeat (3) @(posedge clk24);
        #1;
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("reset_dly", 32'({LHBL_dly, LVBL_dly}), 32'd0);

        for (int i = 0; i < 512; i++) cpu_wr(9'(i), 8'($urandom));
        @(negedge clk24);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cpu_rd(9'($urandom_range(0, 511)));

        cpu_wr(9'h000, 8'h1F);
        cpu_wr(9'h001, 8'h7C);
        cpu_rd(9'h001);
        pixel(8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        pixel(8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("entry00", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd31}));

        cpu_wr(9'h10A, 8'hE0);
        cpu_wr(9'h10B, 8'h03);
        cpu_wr(9'h006, 8'h0A);
        cpu_wr(9'h007, 8'h00);
        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        pixel(8'h03, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("front85", 32'({red, green, blue}), 32'({5'd0, 5'd31, 5'd0}));
        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b01, 0, 8'h00);
        chk("back03", 32'({red, green, blue}), 32'({5'd10, 5'd0, 5'd0}));
        pixel(8'h03, 8'h05, 1'b1, 1'b0, 2'b11, 0, 8'h00);
`ifdef JTCONTRA_LAYER_MASK_EN
        chk("mask01", 32'({red, green, blue}), 32'({5'd10, 5'd0, 5'd0}));
`else
        chk("mask01", 32'({red, green, blue}), 32'({5'd0, 5'd31, 5'd0}));
`endif
        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("vblank_rgb", 32'({red, green, blue}), 32'd0);
        chk("vblank_dly", 32'({LHBL_dly, LVBL_dly}), 32'({1'b1, 1'b0}));

        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b11, 1, 8'h1F);
        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("rbw_old", 32'({red, green, blue}), 32'({5'd0, 5'd31, 5'd0}));
        pixel(8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("rbw_new", 32'({red, green, blue}), 32'({5'd31, 5'd24, 5'd0}));

        pixel(8'h03, 8'h05, 1'b1, 1'b1, 2'b11, 2, 8'h00);
        pixel(8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        pixel(8'h03, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);
        chk("post_rst", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd31}));

        for (int i = 0; i < 60; i++) begin
            pixel(8'($urandom), 8'($urandom),
                  ($urandom % 8) != 0, ($urandom % 8) != 0,
                  2'($urandom), 0, 8'h00);
            if ($urandom % 4 == 0)
                cpu_wr(9'($urandom_range(0, 511)), 8'($urandom));
        end
        pixel(8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
